// File: rtl/complex_square_pipe_pkg.sv
// Shared definitions for the complex-square pipeline: mode encodings,
// pipeline depth and accumulator sizing.
package complex_pipe_pkg;

  typedef enum logic [1:0] {
    MODE_SQUARE   = 2'd0,
    MODE_MAG2     = 2'd1,
    MODE_MAG2_ACC = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  localparam int PIPE_LATENCY = 3;

  // Unscaled accumulator must hold acc_len magnitudes of 2*width bits each.
  function automatic int acc_width(input int width, input int acc_len);
    return 2 * width + $clog2(acc_len);
  endfunction

endpackage

// File: rtl/complex_square_pipe_if.sv
// Valid/ready sample-in / result-out bundle of the complex-square pipeline.
interface complex_square_pipe_if #(
  parameter int WIDTH = 16
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_real;
  logic signed [WIDTH-1:0] in_imag;
  logic [1:0]              in_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_real;
  logic signed [WIDTH-1:0] out_imag;
  logic                    out_sat;

  modport master (
    output in_valid, in_real, in_imag, in_mode, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_sat
  );

  modport slave (
    input  in_valid, in_real, in_imag, in_mode, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_sat
  );

endinterface

// File: rtl/complex_square_pipe_sat_scale.sv
// Arithmetic right shift by FRAC (floor) followed by saturation to a signed
// WIDTH-bit result; sat flags that clipping happened.
module complex_sat_scale #(
  parameter int IN_W  = 34,
  parameter int WIDTH = 16,
  parameter int FRAC  = 0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [WIDTH-1:0] dout,
  output logic                    sat
);

  localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [IN_W-1:0] shifted;

  assign shifted = din >>> FRAC;

  always_comb begin
    dout = shifted[WIDTH-1:0];
    sat  = 1'b0;
    if (shifted > MAX_V) begin
      dout = {1'b0, {(WIDTH-1){1'b1}}};
      sat  = 1'b1;
    end else if (shifted < MIN_V) begin
      dout = {1'b1, {(WIDTH-1){1'b0}}};
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/complex_square_pipe.sv
// Three-stage complex square / magnitude-squared / accumulated-magnitude unit
// with a single global stall driven by the output handshake.
module complex_square_pipe
  import complex_pipe_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 0,
  parameter int ACC_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  complex_square_pipe_if.slave  bus
);

  localparam int PW    = 2 * WIDTH;
  localparam int AW    = acc_width(WIDTH, ACC_LEN);
  localparam int CW    = (AW > PW + 2) ? AW : PW + 2;
  localparam int CNT_W = $clog2(ACC_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  logic advance;

  logic                    s1_valid_reg;
  logic signed [WIDTH-1:0] s1_real_reg;
  logic signed [WIDTH-1:0] s1_imag_reg;
  mode_e                   s1_mode_reg;

  logic                    s2_valid_reg;
  logic signed [PW-1:0]    s2_rr_reg;
  logic signed [PW-1:0]    s2_ii_reg;
  logic signed [PW-1:0]    s2_ri_reg;
  mode_e                   s2_mode_reg;

  logic signed [AW-1:0]    acc_reg;
  logic [CNT_W-1:0]        cnt_reg;

  logic                    out_valid_reg;
  logic signed [WIDTH-1:0] out_real_reg;
  logic signed [WIDTH-1:0] out_imag_reg;
  logic                    out_sat_reg;

  logic signed [PW-1:0]    rr_p;
  logic signed [PW-1:0]    ii_p;
  logic signed [PW-1:0]    ri_p;

  logic signed [CW-1:0]    mag_x;
  logic signed [CW-1:0]    acc_sum;
  logic                    is_acc;
  logic                    acc_last;

  logic signed [CW-1:0]    lane_full [2];
  logic signed [WIDTH-1:0] lane_out  [2];
  logic                    lane_sat  [2];

  // A stalled output freezes the whole pipe; bubbles are never squeezed out.
  assign advance      = !out_valid_reg || bus.out_ready;
  assign bus.in_ready = advance;

  assign bus.out_valid = out_valid_reg;
  assign bus.out_real  = out_real_reg;
  assign bus.out_imag  = out_imag_reg;
  assign bus.out_sat   = out_sat_reg;

  assign rr_p = PW'(s1_real_reg) * PW'(s1_real_reg);
  assign ii_p = PW'(s1_imag_reg) * PW'(s1_imag_reg);
  assign ri_p = PW'(s1_real_reg) * PW'(s1_imag_reg);

  assign mag_x    = CW'(s2_rr_reg) + CW'(s2_ii_reg);
  assign acc_sum  = CW'(acc_reg) + mag_x;
  assign is_acc   = (s2_mode_reg == MODE_MAG2_ACC);
  assign acc_last = is_acc && (cnt_reg == LAST_CNT);

  // Reserved mode falls through to the SQUARE default.
  always_comb begin
    lane_full[0] = CW'(s2_rr_reg) - CW'(s2_ii_reg);
    lane_full[1] = CW'(s2_ri_reg) <<< 1;
    case (s2_mode_reg)
      MODE_MAG2: begin
        lane_full[0] = mag_x;
        lane_full[1] = '0;
      end
      MODE_MAG2_ACC: begin
        lane_full[0] = acc_sum;
        lane_full[1] = '0;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    complex_sat_scale #(
      .IN_W  (CW),
      .WIDTH (WIDTH),
      .FRAC  (FRAC)
    ) u_scale (
      .din  (lane_full[gi]),
      .dout (lane_out[gi]),
      .sat  (lane_sat[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg  <= 1'b0;
      s1_real_reg   <= '0;
      s1_imag_reg   <= '0;
      s1_mode_reg   <= MODE_SQUARE;
      s2_valid_reg  <= 1'b0;
      s2_rr_reg     <= '0;
      s2_ii_reg     <= '0;
      s2_ri_reg     <= '0;
      s2_mode_reg   <= MODE_SQUARE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_real_reg  <= '0;
      out_imag_reg  <= '0;
      out_sat_reg   <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= bus.in_valid;
      s1_real_reg  <= bus.in_real;
      s1_imag_reg  <= bus.in_imag;
      s1_mode_reg  <= mode_e'(bus.in_mode);

      s2_valid_reg <= s1_valid_reg;
      s2_rr_reg    <= rr_p;
      s2_ii_reg    <= ii_p;
      s2_ri_reg    <= ri_p;
      s2_mode_reg  <= s1_mode_reg;

      out_valid_reg <= 1'b0;
      if (s2_valid_reg) begin
        if (is_acc && !acc_last) begin
          acc_reg <= acc_sum[AW-1:0];
          cnt_reg <= cnt_reg + CNT_W'(1);
        end else begin
          // Group end, or a non-ACC beat abandoning any partial sum.
          acc_reg       <= '0;
          cnt_reg       <= '0;
          out_valid_reg <= 1'b1;
          out_real_reg  <= lane_out[0];
          out_imag_reg  <= lane_out[1];
          out_sat_reg   <= lane_sat[0] | lane_sat[1];
        end
      end
    end
  end

endmodule

// File: doc/complex_square_pipe.md
# complex_square_pipe

Pipelined, parametrised successor to the combinational complex-square unit in the dot-product datapath. Accepts one signed complex sample per cycle over a valid/ready handshake and computes, per beat, the complex square (a²), the magnitude squared (|a|²), or |a|² accumulated over ACC_LEN samples. Output is fixed-point scaled and saturated to WIDTH. Sits between the sample front-end and the sorter's metric stage.

## Interface
- WIDTH, 16: bit width of each signed two's-complement real/imag component, in and out.
- FRAC, 0: fractional bits of the Q-format; full products are arithmetically shifted right by FRAC.
- ACC_LEN, 4: samples per accumulated result in MAG2_ACC mode; must be ≥ 2.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_real  in  WIDTH  signed real part.
- in_imag  in  WIDTH  signed imaginary part.
- in_mode  in  2  per-beat mode: 0 SQUARE, 1 MAG2, 2 MAG2_ACC, 3 reserved (processed as SQUARE).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out_real  out  WIDTH  result real part.
- out_imag  out  WIDTH  result imaginary part; 0 in MAG2 / MAG2_ACC.
- out_sat  out  1  this result saturated in either component.

## Operation
- Beat transfers on in_valid && in_ready; result transfers on out_valid && out_ready.
- Stage 1 registers the sample and mode. Stage 2 registers full-width signed products re², im², re·im (2·WIDTH each). Stage 3 combines, scales, saturates into the output registers.
- SQUARE: real = re² − im², imag = 2·re·im, each computed in 2·WIDTH+2 bits, no intermediate wrap.
- MAG2: real = re² + im², imag = 0.
- Scaling: arithmetic shift right by FRAC (floor, no rounding), then saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; out_sat = OR of both components' saturation.
- MAG2_ACC: accumulator (2·WIDTH + clog2(ACC_LEN) bits, unscaled) adds re²+im² per beat; counter 0..ACC_LEN−1. Beat with count = ACC_LEN−1 produces one output beat (sum scaled/saturated, imag 0) and clears count and accumulator; other ACC beats produce no output.
- A non-ACC beat reaching stage 3 while count > 0 discards the partial sum (count and accumulator cleared) and is processed normally.
- Reserved mode 3 is indistinguishable from SQUARE at the outputs.

## Timing
- Latency: beat accepted at edge n is on the outputs after edge n+2 (three register stages); throughput one beat per cycle.
- Global stall: advance = !out_valid || out_ready; in_ready = advance. All stages, counter and accumulator hold when advance is low. Bubbles are not compressed.
- out_* stable while out_valid && !out_ready.
- in_ready combinationally depends on out_ready; no other combinational in→out paths.
- Reset (any time, including mid-accumulation or during stall): all valid bits, counter, accumulator cleared; out_valid 0, out_real 0, out_imag 0, out_sat 0; in_ready reads 1 while in reset. In-flight beats are lost, no result emitted for them.

## Structure
- Package complex_pipe_pkg: mode encodings (MODE_SQUARE, MODE_MAG2, MODE_MAG2_ACC), localparam PIPE_LATENCY = 3, accumulator-width function.
- One sub-module: complex_sat_scale (parameter IN_W, WIDTH, FRAC; shift + saturate + sat flag), instantiated twice for real and imag in stage 3.

## Test plan
- WIDTH=16, FRAC=0, SQUARE 3+j4, out_ready=1 -> after 3 edges out −7+j24, out_sat 0; MAG2 3+j4 -> 25+j0.
- FRAC=14, SQUARE 8192+j8192 (0.5+j0.5) -> 0+j8192; back-to-back stream of 16 random beats -> one result per cycle, exact model match.
- FRAC=0, SQUARE 300+j0 -> 32767+j0, out_sat 1; SQUARE −32768+j0 -> 32767, out_sat 1; SQUARE 0+j300 -> −32768+j0, out_sat 1.
- ACC_LEN=4, MAG2_ACC beats 1+j1, 2+j0, 0+j3, 1+j2 -> single output 20+j0; 2 ACC beats then SQUARE 3+j4 -> only −7+j24 emitted, next 4 ACC beats of 1+j0 -> 4.
- Stream 8 beats with out_ready low for 5 cycles mid-stream -> in_ready low during stall, outputs held stable, all 8 results in order, none duplicated.
- Assert rst_n low asynchronously with 3 beats in flight and ACC count 2 -> outputs 0 immediately, no stale result after release, next ACC group needs a full 4 beats.
